ram_resp: RTL and testbench

- Synthesizable 64-bit memory responder. It answers the ramtest request/ack protocol on two ports: an instruction port (read-only) and a data port (read/write).
- It stands in for ramctrl in on-chip bring-up and bench configurations. It is backed by a 2^AW x 64 block RAM, with configurable wait states and timeout signalling for unimplemented addresses.
- The interface is pin-compatible with ramctrl.

---
 rtl/ram_resp.sv | 177 +++++++++++++++++
 tb/tb_ram_resp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_resp.sv
// Block-RAM backed memory responder for the ramtest request/ack protocol.
// One transaction in flight; round-robin between instruction and data ports.
module ram_resp #(
    parameter int AW      = 10,
    parameter int LATENCY = 4,
    parameter int TIMEOUT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_ok,
    input  logic        inst_stb,
    input  logic [25:0] inst_addr,
    output logic [63:0] inst_dout,
    output logic        inst_ack,
    output logic        inst_timeout,
    input  logic        data_stb,
    input  logic        data_we,
    input  logic [25:0] data_addr,
    input  logic [63:0] data_din,
    output logic [63:0] data_dout,
    output logic        data_ack,
    output logic        data_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
    localparam logic [7:0] TO_LOAD  = 8'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [7:0]      count_reg, count_next;
    logic            grant_data_reg, grant_data_next;
    logic            last_data_reg, last_data_next;
    logic [AW-1:0]   idx_reg, idx_next;
    logic            we_reg, we_next;
    logic [63:0]     din_reg, din_next;
    logic            in_range_reg, in_range_next;
    logic            inst_ack_reg, inst_ack_next;
    logic            inst_timeout_reg, inst_timeout_next;
    logic            data_ack_reg, data_ack_next;
    logic            data_timeout_reg, data_timeout_next;
    logic [63:0]     inst_dout_reg, inst_dout_next;
    logic [63:0]     data_dout_reg, data_dout_next;

    logic [63:0]     mem [0:(2**AW)-1];
    logic [63:0]     rd_word;
    logic            mem_we;
    logic            pick_data;
    logic [25:0]     req_addr;
    logic            req_in_range;

    // On a tie the port that did not win last time is granted.
    assign pick_data    = data_stb && (!inst_stb || !last_data_reg);
    assign req_addr     = pick_data ? data_addr : inst_addr;
    assign req_in_range = ((req_addr >> AW) == 26'd0);

    // The captured index acts as the RAM's registered read address.
    assign rd_word = mem[idx_reg];
    assign mem_we  = (state_reg == WAIT) && (count_reg == 8'd0) && in_range_reg && we_reg;

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        grant_data_next   = grant_data_reg;
        last_data_next    = last_data_reg;
        idx_next          = idx_reg;
        we_next           = we_reg;
        din_next          = din_reg;
        in_range_next     = in_range_reg;
        inst_ack_next     = 1'b0;
        inst_timeout_next = 1'b0;
        data_ack_next     = 1'b0;
        data_timeout_next = 1'b0;
        inst_dout_next    = inst_dout_reg;
        data_dout_next    = data_dout_reg;

        case (state_reg)
            IDLE: begin
                if (clk_ok && (inst_stb || data_stb)) begin
                    state_next      = WAIT;
                    grant_data_next = pick_data;
                    last_data_next  = pick_data;
                    idx_next        = req_addr[AW-1:0];
                    we_next         = pick_data && data_we;
                    din_next        = data_din;
                    in_range_next   = req_in_range;
                    count_next      = req_in_range ? LAT_LOAD : TO_LOAD;
                end
            end
            WAIT: begin
                if (count_reg == 8'd0) begin
                    state_next = RESP;
                    if (in_range_reg) begin
                        if (grant_data_reg) begin
                            data_ack_next = 1'b1;
                            if (!we_reg) begin
                                data_dout_next = rd_word;
                            end
                        end else begin
                            inst_ack_next  = 1'b1;
                            inst_dout_next = rd_word;
                        end
                    end else begin
                        if (grant_data_reg) begin
                            data_timeout_next = 1'b1;
                            data_dout_next    = 64'd0;
                        end else begin
                            inst_timeout_next = 1'b1;
                            inst_dout_next    = 64'd0;
                        end
                    end
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            count_reg        <= 8'd0;
            grant_data_reg   <= 1'b0;
            last_data_reg    <= 1'b0;
            idx_reg          <= '0;
            we_reg           <= 1'b0;
            din_reg          <= 64'd0;
            in_range_reg     <= 1'b0;
            inst_ack_reg     <= 1'b0;
            inst_timeout_reg <= 1'b0;
            data_ack_reg     <= 1'b0;
            data_timeout_reg <= 1'b0;
            inst_dout_reg    <= 64'd0;
            data_dout_reg    <= 64'd0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            grant_data_reg   <= grant_data_next;
            last_data_reg    <= last_data_next;
            idx_reg          <= idx_next;
            we_reg           <= we_next;
            din_reg          <= din_next;
            in_range_reg     <= in_range_next;
            inst_ack_reg     <= inst_ack_next;
            inst_timeout_reg <= inst_timeout_next;
            data_ack_reg     <= data_ack_next;
            data_timeout_reg <= data_timeout_next;
            inst_dout_reg    <= inst_dout_next;
            data_dout_reg    <= data_dout_next;
        end
    end

    // RAM contents survive reset; an aborted transaction never reaches mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_reg] <= din_reg;
        end
    end

    assign inst_dout    = inst_dout_reg;
    assign inst_ack     = inst_ack_reg;
    assign inst_timeout = inst_timeout_reg;
    assign data_dout    = data_dout_reg;
    assign data_ack     = data_ack_reg;
    assign data_timeout = data_timeout_reg;

endmodule

// File: tb/tb_ram_resp.sv
// Self-checking bench for ram_resp: directed scenarios plus randomized traffic
// compared against a word-array memory model and transaction-level timing rules.
module tb_ram_resp;

    localparam int AW      = 10;
    localparam int LATENCY = 4;
    localparam int TIMEOUT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_ok = 1'b0;
    logic        inst_stb = 1'b0;
    logic [25:0] inst_addr = '0;
    logic [63:0] inst_dout;
    logic        inst_ack;
    logic        inst_timeout;
    logic        data_stb = 1'b0;
    logic        data_we = 1'b0;
    logic [25:0] data_addr = '0;
    logic [63:0] data_din = '0;
    logic [63:0] data_dout;
    logic        data_ack;
    logic        data_timeout;

    logic [3:0]  flags;
    assign flags = {inst_ack, inst_timeout, data_ack, data_timeout};

    int checks   = 0;
    int failures = 0;

    logic [63:0] model_mem [int];
    logic [63:0] exp_inst_dout = 64'd0;
    logic [63:0] exp_data_dout = 64'd0;
    bit          model_last_data = 1'b0;

    ram_resp #(.AW(AW), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .clk_ok(clk_ok),
        .inst_stb(inst_stb), .inst_addr(inst_addr), .inst_dout(inst_dout),
        .inst_ack(inst_ack), .inst_timeout(inst_timeout),
        .data_stb(data_stb), .data_we(data_we), .data_addr(data_addr),
        .data_din(data_din), .data_dout(data_dout),
        .data_ack(data_ack), .data_timeout(data_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // At most one response flag in any cycle.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            assert ($countones(flags) <= 1) else begin
                failures++;
                $error("FAIL one_hot_resp observed=%b expected=at_most_one", flags);
            end
        end
    end

    function automatic bit in_range(input logic [25:0] a);
        return int'(a) < (1 << AW);
    endfunction

    // Issue one request on an idle responder and follow it to completion.
    task automatic txn(input bit is_data, input bit we, input logic [25:0] addr,
                       input logic [63:0] din, input int drop_ok_after);
        bit         rng;
        bit         resp;
        int         n;
        logic [3:0] exp_flags;
        rng  = in_range(addr);
        resp = 1'b0;
        n    = 0;
        if (is_data) begin
            data_stb = 1'b1; data_we = we; data_addr = addr; data_din = din;
        end else begin
            inst_stb = 1'b1; inst_addr = addr;
        end
        while (!resp && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                // request fields are latched at capture; later changes must be ignored
                if (is_data) begin
                    data_addr = 26'($urandom);
                    data_din  = {$urandom, $urandom};
                    data_we   = 1'($urandom);
                end else begin
                    inst_addr = 26'($urandom);
                end
            end
            if (drop_ok_after != 0 && n == drop_ok_after) clk_ok = 1'b0;
            if (flags != 4'b0000) resp = 1'b1;
        end
        check("resp_seen", 64'(resp), 64'd1);
        check("resp_latency", 64'(n - 1), 64'(rng ? LATENCY : TIMEOUT));
        if (is_data) exp_flags = rng ? 4'b0010 : 4'b0001;
        else         exp_flags = rng ? 4'b1000 : 4'b0100;
        check("resp_flags", 64'(flags), 64'(exp_flags));
        inst_stb = 1'b0; data_stb = 1'b0; data_we = 1'b0;
        clk_ok   = 1'b1;
        model_last_data = is_data;
        if (!rng) begin
            if (is_data) exp_data_dout = 64'd0; else exp_inst_dout = 64'd0;
        end else if (is_data && we) begin
            model_mem[int'(addr)] = din;
        end else if (model_mem.exists(int'(addr))) begin
            if (is_data) exp_data_dout = model_mem[int'(addr)];
            else         exp_inst_dout = model_mem[int'(addr)];
        end
        check("inst_dout", inst_dout, exp_inst_dout);
        check("data_dout", data_dout, exp_data_dout);
        @(posedge clk); #1;
        check("pulse_width", 64'(flags), 64'd0);
    endtask

    // Both ports request together and hold through four completions.
    task automatic arbitrate(input logic [25:0] a_inst, input logic [25:0] a_data);
        int nacks;
        int prev_n;
        int n;
        bit exp_data;
        nacks = 0; prev_n = 0; n = 0;
        exp_data = !model_last_data;
        inst_stb = 1'b1; inst_addr = a_inst;
        data_stb = 1'b1; data_we = 1'b0; data_addr = a_data;
        while (nacks < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (flags != 4'b0000) begin
                check("arb_flags", 64'(flags), 64'(exp_data ? 4'b0010 : 4'b1000));
                if (nacks == 0) check("arb_first_lat", 64'(n - 1), 64'(LATENCY));
                else            check("arb_gap", 64'(n - prev_n), 64'(LATENCY + 2));
                if (exp_data) exp_data_dout = model_mem[int'(a_data)];
                else          exp_inst_dout = model_mem[int'(a_inst)];
                model_last_data = exp_data;
                exp_data = !exp_data;
                prev_n = n;
                nacks++;
            end
        end
        check("arb_count", 64'(nacks), 64'd4);
        inst_stb = 1'b0; data_stb = 1'b0;
        check("arb_inst_dout", inst_dout, exp_inst_dout);
        check("arb_data_dout", data_dout, exp_data_dout);
        @(posedge clk); #1;
        check("arb_pulse_width", 64'(flags), 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [25:0] pool [8];
        logic [63:0] prior7;

        // reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", 64'(flags), 64'd0);
        check("reset_inst_dout", inst_dout, 64'd0);
        check("reset_data_dout", data_dout, 64'd0);
        rst = 1'b1; clk_ok = 1'b1;
        @(posedge clk); #1;

        // basic write, read-back on both ports
        txn(1'b1, 1'b1, 26'h5, 64'h0123456789ABCDEF, 0);
        txn(1'b1, 1'b0, 26'h5, 64'd0, 0);
        txn(1'b0, 1'b0, 26'h5, 64'd0, 0);

        pool[0] = 26'h000; pool[1] = 26'h007; pool[2] = 26'h3FF; pool[3] = 26'h012;
        pool[4] = 26'h02A; pool[5] = 26'h100; pool[6] = 26'h200; pool[7] = 26'h005;
        for (int i = 0; i < 7; i++) txn(1'b1, 1'b1, pool[i], {$urandom, $urandom}, 0);

        // out-of-range accesses time out and leave RAM alone
        txn(1'b1, 1'b1, 26'h400, 64'hDEADBEEFCAFEF00D, 0);
        txn(1'b1, 1'b0, 26'h000, 64'd0, 0);
        txn(1'b0, 1'b0, 26'h2000000, 64'd0, 0);

        // clk_ok gating
        clk_ok = 1'b0; inst_stb = 1'b1; inst_addr = 26'h5; seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (flags != 4'b0000) seen = 1'b1;
        end
        check("clk_ok_low_idle", 64'(seen), 64'd0);
        clk_ok = 1'b1;
        txn(1'b0, 1'b0, 26'h5, 64'd0, 0);
        txn(1'b1, 1'b0, 26'h3FF, 64'd0, 2);

        // reset in the middle of a write
        prior7 = model_mem[7];
        data_stb = 1'b1; data_we = 1'b1; data_addr = 26'h7; data_din = 64'hFF;
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; #1;
        check("rst_mid_flags", 64'(flags), 64'd0);
        check("rst_mid_inst_dout", inst_dout, 64'd0);
        check("rst_mid_data_dout", data_dout, 64'd0);
        data_stb = 1'b0; data_we = 1'b0; seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (flags != 4'b0000) seen = 1'b1;
        end
        check("rst_mid_no_ack", 64'(seen), 64'd0);
        rst = 1'b1;
        exp_inst_dout = 64'd0; exp_data_dout = 64'd0; model_last_data = 1'b0;
        @(posedge clk); #1;
        arbitrate(26'h012, 26'h02A);
        txn(1'b1, 1'b0, 26'h7, 64'd0, 0);
        check("rst_mid_ram_kept", data_dout, prior7);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            bit          d;
            bit          w;
            logic [25:0] a;
            d = 1'($urandom);
            w = d && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) a = 26'(1024 + $urandom_range(0, 5000));
            else                           a = pool[$urandom_range(0, 7)];
            txn(d, w, a, {$urandom, $urandom}, 0);
        end
        arbitrate(26'h100, 26'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
